// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles every signal of the arbiter except clock and reset: the
//   instruction-fetch requester (i_im_*/o_im_*), the data requester
//   (i_dm_*/o_dm_*), the shared memory bus (o_mem_*/i_mem_*) and status
//   (o_err, o_busy, o_dbg_state). Signal names are written from the
//   arbiter's point of view.
//   Modports:
//     slave  - the arbiter (serves both requesters, drives the bus)
//     master - the environment (requesters plus memory)
//
// Handshake rules (all three channels):
//   A request is raised and held, with its attributes stable, until the
//   matching completion is seen; the completion is a one-cycle pulse and
//   the transfer happens in exactly that cycle. For the requesters the
//   completion is o_im_ack/o_dm_ack; for the memory bus it is i_mem_ack,
//   which is only meaningful while o_mem_req is high. A request still
//   high in the cycle after its completion is a brand-new transaction.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_im_req;
    logic [ADDR_W-1:0] i_im_addr;
    logic [DATA_W-1:0] o_im_rdata;
    logic              o_im_ack;

    logic              i_dm_req;
    logic              i_dm_wen;
    logic [ADDR_W-1:0] i_dm_addr;
    logic [DATA_W-1:0] i_dm_wdata;
    logic [3:0]        i_dm_be;
    logic [DATA_W-1:0] o_dm_rdata;
    logic              o_dm_ack;

    logic              o_err;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [3:0]        o_mem_be;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ack;

    logic              o_busy;
    logic [1:0]        o_dbg_state;

    modport slave (
        input  i_im_req, i_im_addr,
        output o_im_rdata, o_im_ack,
        input  i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_be,
        output o_dm_rdata, o_dm_ack,
        output o_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_rdata, i_mem_ack,
        output o_busy, o_dbg_state
    );

    modport master (
        output i_im_req, i_im_addr,
        input  o_im_rdata, o_im_ack,
        output i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_be,
        input  o_dm_rdata, o_dm_ack,
        input  o_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_rdata, i_mem_ack,
        input  o_busy, o_dbg_state
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Lets the instruction-fetch port and the data port share one
//   single-ported memory bus. One transaction at a time: IDLE grants a
//   requester (round-robin on ties), MEM holds the request on the bus until
//   the memory acks or the timeout expires, RESP returns a one-cycle ack
//   (with o_err on timeout) to the winner.
//   Ports:
//     i_clk, i_rst - clock, asynchronous active-high reset
//     bus          - mem_bus_arbiter_if.slave (requesters, memory bus,
//                    o_err, o_busy, o_dbg_state = current FSM state)
//   Parameters: ADDR_W, DATA_W, TIMEOUT (MEM cycles before abort, 1..255)
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic GRANT_IM = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // The counter holds the number of MEM cycles already completed, so the
    // abort fires at the end of MEM cycle number TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic              last_grant_q;
    logic              winner_q;
    logic [7:0]        cnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic [DATA_W-1:0] im_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              im_ack_q;
    logic              dm_ack_q;
    logic              err_q;

    // DM wins when it is alone, or on a tie when IM had the last grant.
    logic grant_dm_d;
    always_comb begin
        grant_dm_d = bus.i_dm_req && (!bus.i_im_req || (last_grant_q == GRANT_IM));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_IM;
            winner_q     <= GRANT_IM;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            im_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            im_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Acks and the error flag are single-cycle pulses by default.
            im_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_im_req || bus.i_dm_req) begin
                        winner_q     <= grant_dm_d;
                        last_grant_q <= grant_dm_d;
                        mem_req_q    <= 1'b1;
                        cnt_q        <= '0;
                        if (grant_dm_d) begin
                            mem_we_q    <= bus.i_dm_wen;
                            mem_addr_q  <= bus.i_dm_addr;
                            mem_wdata_q <= bus.i_dm_wdata;
                            mem_be_q    <= bus.i_dm_wen ? bus.i_dm_be : 4'hF;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.i_im_addr;
                            mem_wdata_q <= '0;
                            mem_be_q    <= 4'hF;
                        end
                        state_q <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A real ack in the last allowed cycle beats the timeout.
                    if (bus.i_mem_ack || (cnt_q == CNT_LAST)) begin
                        mem_req_q <= 1'b0;
                        err_q     <= !bus.i_mem_ack;
                        if (winner_q == GRANT_DM) begin
                            dm_rdata_q <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
                            dm_ack_q   <= 1'b1;
                        end else begin
                            im_rdata_q <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
                            im_ack_q   <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_im_rdata  = im_rdata_q;
    assign bus.o_im_ack    = im_ack_q;
    assign bus.o_dm_rdata  = dm_rdata_q;
    assign bus.o_dm_ack    = dm_ack_q;
    assign bus.o_err       = err_q;
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_be    = mem_be_q;
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_dbg_state = state_q;

endmodule
